// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b tables and constants: 5b/6b and 3b/4b sub-block lookups,
// legal K-character test, bit-reversal helpers and code-word widths.
package enc8b10b_pkg;

    localparam int SYM_W   = 10;
    localparam int WORD_W  = 8;
    localparam int SUB6_W  = 6;
    localparam int SUB4_W  = 4;
    localparam int PRIME_W = 16;
    localparam logic [7:0] K28_5 = 8'hBC;

    // RD- column, written abcdei with 'a' in bit 5; RD+ is the complement where it differs
    function automatic logic [SUB6_W-1:0] fn_5b6b(input logic [4:0] x);
        logic [SUB6_W-1:0] r;
        case (x)
            5'd0:    r = 6'b100111;
            5'd1:    r = 6'b011101;
            5'd2:    r = 6'b101101;
            5'd3:    r = 6'b110001;
            5'd4:    r = 6'b110101;
            5'd5:    r = 6'b101001;
            5'd6:    r = 6'b011001;
            5'd7:    r = 6'b111000;
            5'd8:    r = 6'b111001;
            5'd9:    r = 6'b100101;
            5'd10:   r = 6'b010101;
            5'd11:   r = 6'b110100;
            5'd12:   r = 6'b001101;
            5'd13:   r = 6'b101100;
            5'd14:   r = 6'b011100;
            5'd15:   r = 6'b010111;
            5'd16:   r = 6'b011011;
            5'd17:   r = 6'b100011;
            5'd18:   r = 6'b010011;
            5'd19:   r = 6'b110010;
            5'd20:   r = 6'b001011;
            5'd21:   r = 6'b101010;
            5'd22:   r = 6'b011010;
            5'd23:   r = 6'b111010;
            5'd24:   r = 6'b110011;
            5'd25:   r = 6'b100110;
            5'd26:   r = 6'b010110;
            5'd27:   r = 6'b110110;
            5'd28:   r = 6'b001110;
            5'd29:   r = 6'b101110;
            5'd30:   r = 6'b011110;
            5'd31:   r = 6'b101011;
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    // Data 3b/4b, RD- column written fghj with 'f' in bit 3 (primary D.x.P7 for y=7)
    function automatic logic [SUB4_W-1:0] fn_3b4b_d(input logic [2:0] y);
        logic [SUB4_W-1:0] r;
        case (y)
            3'd0:    r = 4'b1011;
            3'd1:    r = 4'b1001;
            3'd2:    r = 4'b0101;
            3'd3:    r = 4'b1100;
            3'd4:    r = 4'b1101;
            3'd5:    r = 4'b1010;
            3'd6:    r = 4'b0110;
            3'd7:    r = 4'b1110;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [SUB4_W-1:0] fn_3b4b_k(input logic [2:0] y);
        logic [SUB4_W-1:0] r;
        case (y)
            3'd0:    r = 4'b1011;
            3'd1:    r = 4'b0110;
            3'd2:    r = 4'b1010;
            3'd3:    r = 4'b1100;
            3'd4:    r = 4'b1101;
            3'd5:    r = 4'b0101;
            3'd6:    r = 4'b1001;
            3'd7:    r = 4'b0111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic fn_k_legal(input logic [7:0] b);
        logic r;
        if (b[4:0] == 5'd28) begin
            r = 1'b1;
        end else begin
            r = (b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                     (b[4:0] == 5'd29) || (b[4:0] == 5'd30));
        end
        return r;
    endfunction

    // D.x.A7 avoids a run of five identical bits across the sub-block boundary
    function automatic logic fn_use_a7(input logic [4:0] x, input logic rd);
        logic r;
        if (rd) begin
            r = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        end else begin
            r = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        end
        return r;
    endfunction

    function automatic logic [SUB6_W-1:0] fn_rev6(input logic [SUB6_W-1:0] v);
        logic [SUB6_W-1:0] r;
        for (int i = 0; i < SUB6_W; i++) r[i] = v[SUB6_W-1-i];
        return r;
    endfunction

    function automatic logic [SUB4_W-1:0] fn_rev4(input logic [SUB4_W-1:0] v);
        logic [SUB4_W-1:0] r;
        for (int i = 0; i < SUB4_W; i++) r[i] = v[SUB4_W-1-i];
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] fn_rev8(input logic [WORD_W-1:0] v);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) r[i] = v[WORD_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/enc_8b10b_gearbox_if.sv
// Byte/K input stream and serializer-side output bundle of the 8b/10b gearbox.
interface enc_8b10b_gearbox_if;
    logic [7:0] data_in;
    logic       k_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       rd_out;
    logic       code_err;
    logic       ovf_err;
    logic       unf_err;

    modport master (
        output data_in, k_in, valid_in,
        input  data_out, valid_out, rd_out, code_err, ovf_err, unf_err
    );

    modport slave (
        input  data_in, k_in, valid_in,
        output data_out, valid_out, rd_out, code_err, ovf_err, unf_err
    );
endinterface

// File: rtl/enc_8b10b_core.sv
// Encode stage: one byte (+K flag) per valid clock into a registered 10-bit
// symbol {j,h,g,f,i,e,d,c,b,a}, tracking running disparity per sub-block.
module enc_8b10b_core
    import enc8b10b_pkg::*;
#(
    parameter logic [7:0] K_FILL = K28_5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             k,
    input  logic             valid,
    output logic [SYM_W-1:0] code,
    output logic             code_vld,
    output logic             rd,
    output logic             k_bad
);

    logic [SYM_W-1:0]  code_r;
    logic              code_vld_r;
    logic              rd_r;
    logic              k_bad_r;
    logic [7:0]        byte_s;
    logic              illegal_s;
    logic [4:0]        x_s;
    logic [2:0]        y_s;
    logic [SUB6_W-1:0] six_s;
    logic [SUB6_W-1:0] six_rd_s;
    logic              unbal6_s;
    logic              flip6_s;
    logic              rd_mid_s;
    logic [SUB4_W-1:0] four_s;
    logic [SUB4_W-1:0] four_rd_s;
    logic              unbal4_s;
    logic              flip4_s;
    logic              rd_next_s;
    logic [SYM_W-1:0]  code_s;

    // Table lookup and disparity selection for the current byte
    always_comb begin
        byte_s    = data;
        illegal_s = 1'b0;
        if (k && !fn_k_legal(data)) begin
            byte_s    = K_FILL;
            illegal_s = 1'b1;
        end else begin
            byte_s    = data;
            illegal_s = 1'b0;
        end
        x_s = byte_s[4:0];
        y_s = byte_s[7:5];

        if (k && (x_s == 5'd28)) begin
            six_s = 6'b001111;
        end else begin
            six_s = fn_5b6b(x_s);
        end
        unbal6_s = ($countones(six_s) != 32'd3);
        // D.7 is balanced yet still alternates with disparity
        flip6_s  = unbal6_s || (!k && (x_s == 5'd7));
        if (rd_r && flip6_s) begin
            six_rd_s = ~six_s;
        end else begin
            six_rd_s = six_s;
        end
        rd_mid_s = rd_r ^ unbal6_s;

        if (k) begin
            four_s  = fn_3b4b_k(y_s);
            flip4_s = 1'b1;
        end else begin
            if ((y_s == 3'd7) && fn_use_a7(x_s, rd_mid_s)) begin
                four_s = 4'b0111;
            end else begin
                four_s = fn_3b4b_d(y_s);
            end
            flip4_s = (y_s == 3'd0) || (y_s == 3'd3) || (y_s == 3'd4) || (y_s == 3'd7);
        end
        unbal4_s = ($countones(four_s) != 32'd2);
        if (rd_mid_s && flip4_s) begin
            four_rd_s = ~four_s;
        end else begin
            four_rd_s = four_s;
        end
        rd_next_s = rd_mid_s ^ unbal4_s;
        code_s    = {fn_rev4(four_rd_s), fn_rev6(six_rd_s)};
    end

    // Symbol register; disparity only moves when a byte is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r     <= {SYM_W{1'b0}};
            code_vld_r <= 1'b0;
            rd_r       <= 1'b0;
            k_bad_r    <= 1'b0;
        end else if (valid) begin
            code_r     <= code_s;
            code_vld_r <= 1'b1;
            rd_r       <= rd_next_s;
            k_bad_r    <= illegal_s;
        end else begin
            code_vld_r <= 1'b0;
            k_bad_r    <= 1'b0;
        end
    end

    assign code     = code_r;
    assign code_vld = code_vld_r;
    assign rd       = rd_r;
    assign k_bad    = k_bad_r;

endmodule

// File: rtl/enc_8b10b_gearbox.sv
// 8b/10b encoder plus 10-to-8 gearbox feeding the serializer one word per clock.
// Optional macro ENC_MSB_FIRST_EN: 'a' leaves on data_out[7] instead of data_out[0].
module enc_8b10b_gearbox
    import enc8b10b_pkg::*;
#(
    parameter int         BUF_W  = 32,
    parameter logic [7:0] K_FILL = K28_5
) (
    input  logic              clk,
    input  logic              rst,
    enc_8b10b_gearbox_if.slave bus
);

    localparam int FILL_W = $clog2(BUF_W + 1);

    logic [SYM_W-1:0]  code_s;
    logic              code_vld_s;
    logic              rd_s;
    logic              k_bad_s;
    logic [BUF_W-1:0]  buf_r;
    logic [FILL_W-1:0] fill_r;
    logic              started_r;
    logic [WORD_W-1:0] data_out_r;
    logic              valid_out_r;
    logic              code_err_r;
    logic              ovf_err_r;
    logic              unf_err_r;
    logic              pop_s;
    logic              unf_s;
    logic              drop_s;
    logic [FILL_W-1:0] fill_pop_s;
    logic [FILL_W:0]   room_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [BUF_W-1:0]  buf_pop_s;
    logic [BUF_W-1:0]  buf_nxt_s;
    logic [WORD_W-1:0] word_s;

    enc_8b10b_core #(
        .K_FILL (K_FILL)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .data     (bus.data_in),
        .k        (bus.k_in),
        .valid    (bus.valid_in),
        .code     (code_s),
        .code_vld (code_vld_s),
        .rd       (rd_s),
        .k_bad    (k_bad_s)
    );

    // Gearbox next state: pop from the bottom first, then append the symbol at the fill point
    always_comb begin
        pop_s      = 1'b0;
        fill_pop_s = fill_r;
        buf_pop_s  = buf_r;
        drop_s     = 1'b0;
        fill_nxt_s = fill_r;
        buf_nxt_s  = buf_r;
        if ((fill_r >= FILL_W'(WORD_W)) && (started_r || (fill_r >= FILL_W'(PRIME_W)))) begin
            pop_s      = 1'b1;
            fill_pop_s = fill_r - FILL_W'(WORD_W);
            buf_pop_s  = buf_r >> WORD_W;
        end else begin
            pop_s      = 1'b0;
            fill_pop_s = fill_r;
            buf_pop_s  = buf_r;
        end
        unf_s  = started_r && (fill_r < FILL_W'(WORD_W));
        room_s = {1'b0, fill_pop_s} + (FILL_W+1)'(SYM_W);
        if (code_vld_s && (room_s > (FILL_W+1)'(BUF_W))) begin
            drop_s     = 1'b1;
            fill_nxt_s = fill_pop_s;
            buf_nxt_s  = buf_pop_s;
        end else if (code_vld_s) begin
            drop_s     = 1'b0;
            fill_nxt_s = fill_pop_s + FILL_W'(SYM_W);
            buf_nxt_s  = buf_pop_s | (BUF_W'(code_s) << fill_pop_s);
        end else begin
            drop_s     = 1'b0;
            fill_nxt_s = fill_pop_s;
            buf_nxt_s  = buf_pop_s;
        end
    end

`ifdef ENC_MSB_FIRST_EN
    assign word_s = fn_rev8(buf_r[WORD_W-1:0]);
`else
    assign word_s = buf_r[WORD_W-1:0];
`endif

    // Buffer, priming state, output word and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r       <= {BUF_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            started_r   <= 1'b0;
            data_out_r  <= {WORD_W{1'b0}};
            valid_out_r <= 1'b0;
            code_err_r  <= 1'b0;
            ovf_err_r   <= 1'b0;
            unf_err_r   <= 1'b0;
        end else begin
            buf_r  <= buf_nxt_s;
            fill_r <= fill_nxt_s;
            if (pop_s) begin
                data_out_r  <= word_s;
                valid_out_r <= 1'b1;
                started_r   <= 1'b1;
            end else begin
                valid_out_r <= 1'b0;
                if (unf_s) begin
                    started_r <= 1'b0;
                end
            end
            if (unf_s) begin
                unf_err_r <= 1'b1;
            end
            if (drop_s) begin
                ovf_err_r <= 1'b1;
            end
            if (k_bad_s) begin
                code_err_r <= 1'b1;
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;
    assign bus.rd_out    = rd_s;
    assign bus.code_err  = code_err_r;
    assign bus.ovf_err   = ovf_err_r;
    assign bus.unf_err   = unf_err_r;

endmodule

// File: tb/tb_enc_8b10b_gearbox.sv
// Self-checking bench for enc_8b10b_gearbox: bit-level scoreboard of expected
// symbols in transmission order, compared word by word as the DUT emits them.
module tb_enc_8b10b_gearbox;

    // Symbols written in line order: leftmost bit ('a') is sent first
    localparam logic [9:0] K285_N = 10'b0011111010;
    localparam logic [9:0] K285_P = 10'b1100000101;
    localparam logic [9:0] D215   = 10'b1010101010;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   sb_q[$];
    bit   sb_en = 1'b1;
    logic exp_rd = 1'b0;
    int   words_seen = 0;

    always #5 clk = ~clk;

    enc_8b10b_gearbox_if bus();

    enc_8b10b_gearbox #(
        .BUF_W  (32),
        .K_FILL (8'hBC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) sb_q.push_back(s[i]);
    endtask

    // One clock; emitted words are popped from the scoreboard and compared
    task automatic tick();
        logic [7:0] exp_w;
        @(posedge clk);
        @(negedge clk);
        if (sb_en && bus.valid_out === 1'b1) begin
            words_seen++;
            total++;
            if (sb_q.size() < 8) begin
                bad++;
                $display("FAIL sb_underrun got=%h queued_bits=%0d", bus.data_out, sb_q.size());
            end else begin
                for (int i = 0; i < 8; i++) exp_w[i] = sb_q.pop_front();
`ifdef ENC_MSB_FIRST_EN
                exp_w = {exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5], exp_w[6], exp_w[7]};
`endif
                if (bus.data_out !== exp_w) begin
                    bad++;
                    $display("FAIL sb_word got=%h exp=%h at %0t", bus.data_out, exp_w, $time);
                end
            end
        end
    endtask

    task automatic send(input logic v, input logic k, input logic [7:0] d, input logic [9:0] sym);
        if (v && sb_en) push_sym(sym);
        bus.valid_in = v;
        bus.k_in     = k;
        bus.data_in  = d;
        tick();
    endtask

    // K28.5 request (or any K expected to come out as K28.5) in the form for the tracked RD
    task automatic send_k(input logic v, input logic [7:0] d);
        send(v, 1'b1, d, exp_rd ? K285_P : K285_N);
        if (v) exp_rd = ~exp_rd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.k_in     = 1'b0;
        bus.data_in  = 8'h00;
        repeat (n) tick();
        rst = 1'b0;
        sb_q.delete();
        exp_rd = 1'b0;
        words_seen = 0;
    endtask

    task automatic test_reset();
        do_reset(5);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.data_out); end
        total++; if (bus.rd_out !== 1'b0) begin bad++; $display("FAIL rst_rd got=%b exp=0", bus.rd_out); end
        total++; if (bus.code_err !== 1'b0) begin bad++; $display("FAIL rst_code_err got=%b exp=0", bus.code_err); end
        total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf_err got=%b exp=0", bus.ovf_err); end
        total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL rst_unf_err got=%b exp=0", bus.unf_err); end
    endtask

    task automatic test_k28_5();
        do_reset(2);
        for (int c = 0; c < 40; c++) begin
            send_k((c % 10) < 8, 8'hBC);
            if ((c % 10) < 8) begin
                total++;
                if (bus.rd_out !== exp_rd) begin bad++; $display("FAIL k285_rd c=%0d got=%b exp=%b", c, bus.rd_out, exp_rd); end
            end
        end
        total++; if (words_seen < 30) begin bad++; $display("FAIL k285_words got=%0d exp>=30", words_seen); end
        total++; if ({bus.code_err, bus.ovf_err, bus.unf_err} !== 3'b000) begin
            bad++; $display("FAIL k285_errs got=%b exp=000", {bus.code_err, bus.ovf_err, bus.unf_err});
        end
    endtask

    task automatic test_d21_5();
        do_reset(2);
        for (int c = 0; c < 30; c++) begin
            send((c % 10) < 8, 1'b0, 8'hB5, D215);
            total++;
            if (bus.rd_out !== 1'b0) begin bad++; $display("FAIL d215_rd c=%0d got=%b exp=0", c, bus.rd_out); end
        end
        total++; if (words_seen < 20) begin bad++; $display("FAIL d215_words got=%0d exp>=20", words_seen); end
    endtask

    task automatic test_illegal_k();
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                total++;
                if (bus.code_err !== 1'b0) begin bad++; $display("FAIL illk_pre got=%b exp=0", bus.code_err); end
                send_k(1'b1, 8'h00);
            end else begin
                send_k((c % 10) < 8, 8'hBC);
            end
            if ((c % 10) < 8) begin
                total++;
                if (bus.rd_out !== exp_rd) begin bad++; $display("FAIL illk_rd c=%0d got=%b exp=%b", c, bus.rd_out, exp_rd); end
            end
        end
        total++; if (bus.code_err !== 1'b1) begin bad++; $display("FAIL illk_code_err got=%b exp=1", bus.code_err); end
    endtask

    task automatic test_overflow();
        int gaps = 0;
        bit seen = 1'b0;
        do_reset(2);
        sb_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            send_k(1'b1, 8'hBC);
            total++;
            if (bus.rd_out !== exp_rd) begin bad++; $display("FAIL ovf_rd c=%0d got=%b exp=%b", c, bus.rd_out, exp_rd); end
            total++;
            if (dut.fill_r > 6'd32) begin bad++; $display("FAIL ovf_fill c=%0d got=%0d max=32", c, dut.fill_r); end
            if (bus.valid_out === 1'b1) seen = 1'b1;
            else if (seen) gaps++;
        end
        total++; if (!seen || gaps != 0) begin bad++; $display("FAIL ovf_continuous seen=%b gaps=%0d exp gaps=0", seen, gaps); end
        total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.ovf_err); end
        total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL ovf_unf got=%b exp=0", bus.unf_err); end
        sb_en = 1'b1;
    endtask

    task automatic test_underflow_reset();
        bit got = 1'b0;
        bit first = 1'b1;
        logic [7:0] first_exp;
        do_reset(2);
        for (int c = 0; c < 20; c++) send_k((c % 10) < 8, 8'hBC);
        total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL unf_early got=%b exp=0", bus.unf_err); end
        for (int i = 0; i < 20 && !got; i++) begin
            send_k(1'b0, 8'hBC);
            if (bus.unf_err === 1'b1) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL unf_timeout got=%b exp=1", bus.unf_err); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL unf_valid got=%b exp=0", bus.valid_out); end
        for (int c = 0; c < 6; c++) send_k(1'b1, 8'hBC);
        rst = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL mrst_data got=%h exp=00", bus.data_out); end
        total++; if (bus.rd_out !== 1'b0) begin bad++; $display("FAIL mrst_rd got=%b exp=0", bus.rd_out); end
        total++; if ({bus.code_err, bus.ovf_err, bus.unf_err} !== 3'b000) begin
            bad++; $display("FAIL mrst_errs got=%b exp=000", {bus.code_err, bus.ovf_err, bus.unf_err});
        end
        rst = 1'b0;
        sb_q.delete();
        exp_rd = 1'b0;
`ifdef ENC_MSB_FIRST_EN
        first_exp = 8'h3E;
`else
        first_exp = 8'h7C;
`endif
        for (int c = 0; c < 20; c++) begin
            send_k((c % 10) < 8, 8'hBC);
            if (c == 0) begin
                total++;
                if (bus.rd_out !== 1'b1) begin bad++; $display("FAIL post_rst_rd got=%b exp=1", bus.rd_out); end
            end
            if (first && bus.valid_out === 1'b1) begin
                first = 1'b0;
                total++;
                if (bus.data_out !== first_exp) begin bad++; $display("FAIL post_rst_word got=%h exp=%h", bus.data_out, first_exp); end
            end
        end
        total++; if (first) begin bad++; $display("FAIL post_rst_timeout got=no_output exp=output"); end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.k_in     = 1'b0;
        bus.data_in  = 8'h00;
        test_reset();
        test_k28_5();
        test_d21_5();
        test_illegal_k();
        test_overflow();
        test_underflow_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
